// File: rtl/split_sweep_pkg.sv
// ============================================================================
// Module  : split_sweep_pkg
// Brief   : Shared FSM state encoding and default LFSR taps for split_sweep_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package split_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } sweep_state_t;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

endpackage

`default_nettype wire

// File: rtl/split_sweep_next.sv
// ============================================================================
// Module  : split_sweep_next
// Brief   : Next-candidate and seed-load generator; SPLIT_SWEEP_LFSR_EN selects
//           Galois LFSR stepping, otherwise a wrapping binary counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module split_sweep_next #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] next_val,
  output logic [WIDTH-1:0] load_val
);

`ifdef SPLIT_SWEEP_LFSR_EN
  assign next_val = (cur >> 1) ^ (cur[0] ? TAPS : '0);
  // All-zero is the LFSR's lock-up state, so never start from it.
  assign load_val = (seed == '0) ? WIDTH'(1) : seed;
`else
  logic unused_taps;
  assign unused_taps = ^TAPS;
  assign next_val    = cur + WIDTH'(1);
  assign load_val    = seed;
`endif

endmodule

`default_nettype wire

// File: rtl/split_sweep_ctrl.sv
// ============================================================================
// Module  : split_sweep_ctrl
// Brief   : Sweeps candidates into a split_N checker until a hit or the budget
//           runs out, then offers the outcome on a valid/ready handshake.
//           Build option: SPLIT_SWEEP_LFSR_EN (LFSR candidate order).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module split_sweep_ctrl
  import split_sweep_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               MAX_ITER = 1024,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              seed,
  output logic [WIDTH-1:0]              cand,
  input  logic                          sat_in,
  output logic                          busy,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic                          found,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int              ITW       = $clog2(MAX_ITER + 1);
  localparam logic [ITW-1:0]  LAST_ITER = ITW'(MAX_ITER - 1);

  sweep_state_t     state, state_nxt;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] load_val;
  logic             budget_out;

  split_sweep_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .cur      (cand),
    .seed     (seed),
    .next_val (next_val),
    .load_val (load_val)
  );

  // The candidate being evaluated now is number iter_count+1.
  assign budget_out = (iter_count == LAST_ITER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                state_nxt = EVAL;
      EVAL:    if (sat_in || budget_out) state_nxt = HOLD;
      HOLD:    if (done_ready)           state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == EVAL);
    done_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= '0;
      result     <= '0;
      found      <= 1'b0;
      iter_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cand       <= load_val;
            iter_count <= '0;
            found      <= 1'b0;
          end
        end
        EVAL: begin
          iter_count <= iter_count + ITW'(1);
          if (sat_in) begin
            result <= cand;
            found  <= 1'b1;
          end else if (budget_out) begin
            result <= cand;
            found  <= 1'b0;
          end else begin
            cand <= next_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
